// File: rtl/traffic_phase_scheduler.sv
// Phase sequencer for a 4-way intersection: NS/EW green arbitration, pedestrian walk phase
// and emergency preemption, all timed in slow ticks. Lamp/walk outputs are registered.
module traffic_phase_scheduler #(
    parameter int unsigned CW        = 6,
    parameter int unsigned MIN_GREEN = 5,
    parameter int unsigned MAX_GREEN = 20,
    parameter int unsigned YELLOW    = 3,
    parameter int unsigned ALL_RED   = 1,
    parameter int unsigned WALK      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] veh_req,
    input  logic       ped_req,
    input  logic       emg_req,
    input  logic       emg_dir,
    output logic [2:0] light_north,
    output logic [2:0] light_south,
    output logic [2:0] light_east,
    output logic [2:0] light_west,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic       emg_active,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StAllRed   = 3'd0,
        StNsGreen  = 3'd1,
        StNsYellow = 3'd2,
        StEwGreen  = 3'd3,
        StEwYellow = 3'd4,
        StPedWalk  = 3'd5,
        StEmgHold  = 3'd6
    } state_e;

    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b001;

    localparam logic [CW-1:0] AllRedLast = CW'(ALL_RED - 1);
    localparam logic [CW-1:0] MinGLast   = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MaxGLast   = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YellowLast = CW'(YELLOW - 1);
    localparam logic [CW-1:0] WalkLast   = CW'(WALK - 1);
    localparam logic [CW-1:0] CntFull    = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, cnt_sat;
    logic          next_axis_q, next_axis_d;  // 0 = NS, 1 = EW
    logic          emg_axis_q, emg_axis_d;
    logic          ped_pending_q, ped_pending_d;
    logic [11:0]   lights_q;                  // {north, south, east, west}
    logic          walk_q, emg_q;

    logic ns_req, ew_req, green_ew, own, conflict;

    // {N, S, E, W} lamp pattern for a given state.
    function automatic logic [11:0] lamps(input state_e st, input logic emg_ax);
        logic [11:0] l;
        unique case (st)
            StNsGreen:  l = {LampG, LampG, LampR, LampR};
            StNsYellow: l = {LampY, LampY, LampR, LampR};
            StEwGreen:  l = {LampR, LampR, LampG, LampG};
            StEwYellow: l = {LampR, LampR, LampY, LampY};
            StEmgHold:  l = emg_ax ? {LampR, LampR, LampG, LampG} : {LampG, LampG, LampR, LampR};
            default:    l = {LampR, LampR, LampR, LampR};
        endcase
        return l;
    endfunction

    always_comb begin
        ns_req      = veh_req[3] | veh_req[2];
        ew_req      = veh_req[1] | veh_req[0];
        green_ew    = (state_q == StEwGreen);
        own         = green_ew ? ew_req : ns_req;
        conflict    = (green_ew ? ns_req : ew_req) | ped_pending_q;

        // Green saturates at MAX_GREEN-1; other states saturate at full scale so an
        // indefinite emergency hold cannot wrap the counter.
        cnt_sat     = ((state_q == StNsGreen) || (state_q == StEwGreen)) ? MaxGLast : CntFull;
        cnt_inc     = (cnt_q >= cnt_sat) ? cnt_q : cnt_q + 1'b1;

        state_d     = state_q;
        next_axis_d = next_axis_q;
        emg_axis_d  = emg_axis_q;

        if (tick) begin
            unique case (state_q)
                StAllRed: begin
                    if (cnt_q == AllRedLast) begin
                        if (emg_req) begin
                            state_d    = StEmgHold;
                            emg_axis_d = emg_dir;
                        end else if (ped_pending_q) begin
                            state_d = StPedWalk;
                        end else begin
                            state_d = next_axis_q ? StEwGreen : StNsGreen;
                        end
                    end
                end
                StNsGreen, StEwGreen: begin
                    if (emg_req && (emg_dir != green_ew)) begin
                        state_d     = green_ew ? StEwYellow : StNsYellow;
                        next_axis_d = ~green_ew;
                    end else if (emg_req) begin
                        state_d    = StEmgHold;
                        emg_axis_d = green_ew;
                    end else if (conflict &&
                                 (((cnt_q >= MinGLast) && !own) || (cnt_q == MaxGLast))) begin
                        state_d     = green_ew ? StEwYellow : StNsYellow;
                        next_axis_d = ~green_ew;
                    end
                end
                StNsYellow, StEwYellow: begin
                    if (cnt_q == YellowLast) state_d = StAllRed;
                end
                StPedWalk: begin
                    if (emg_req || (cnt_q == WalkLast)) state_d = StAllRed;
                end
                StEmgHold: begin
                    if (!emg_req || (emg_dir != emg_axis_q)) begin
                        state_d     = emg_axis_q ? StEwYellow : StNsYellow;
                        next_axis_d = ~emg_axis_q;
                    end
                end
                default: state_d = StAllRed;
            endcase
        end

        cnt_d = cnt_q;
        if (tick) cnt_d = (state_d != state_q) ? '0 : cnt_inc;

        // Walk entry clears the latch even if a button press lands on the same cycle.
        ped_pending_d = ped_pending_q | ped_req;
        if ((state_d == StPedWalk) && (state_q != StPedWalk)) ped_pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StAllRed;
            cnt_q         <= '0;
            next_axis_q   <= 1'b0;
            emg_axis_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            lights_q      <= {LampR, LampR, LampR, LampR};
            walk_q        <= 1'b0;
            emg_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            next_axis_q   <= next_axis_d;
            emg_axis_q    <= emg_axis_d;
            ped_pending_q <= ped_pending_d;
            lights_q      <= lamps(state_d, emg_axis_d);
            walk_q        <= (state_d == StPedWalk);
            emg_q         <= (state_d == StEmgHold);
        end
    end

    assign light_north = lights_q[11:9];
    assign light_south = lights_q[8:6];
    assign light_east  = lights_q[5:3];
    assign light_west  = lights_q[2:0];
    assign ped_walk    = walk_q;
    assign ped_pending = ped_pending_q;
    assign emg_active  = emg_q;
    assign phase       = state_q;

endmodule
